// File: rtl/regfile_wb_writer.sv
// Writeback stage: arbitrates ALU/LSU/MDU results onto the regfile write port.
// Optional REGFILE_WB_FORWARD_EN adds a same-cycle bypass read port.
module regfile_wb_writer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  input  logic            alloc_valid,
  input  logic [4:0]      alloc_rd,
  output logic [31:0]     busy,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] data_des,
  output logic            data_valid
`ifdef REGFILE_WB_FORWARD_EN
  ,
  input  logic [4:0]      fwd_rs,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_data
`endif
);

  localparam logic GNT_LSU = 1'b0;
  localparam logic GNT_MDU = 1'b1;

  logic            last_grant;
  logic            lsu_win;
  logic            mdu_win;
  logic            win_valid;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;
  logic [31:0]     busy_next;

  // On a tie the source not granted last wins
  assign lsu_win = !alu_valid && lsu_valid &&
                   (!mdu_valid || last_grant == GNT_MDU);
  assign mdu_win = !alu_valid && mdu_valid &&
                   (!lsu_valid || last_grant == GNT_LSU);

  assign lsu_ready = lsu_win;
  assign mdu_ready = mdu_win;

  always_comb begin
    win_valid = 1'b0;
    win_rd    = '0;
    win_data  = '0;
    unique case (1'b1)
      alu_valid: begin
        win_valid = 1'b1;
        win_rd    = alu_rd;
        win_data  = alu_data;
      end
      lsu_win: begin
        win_valid = 1'b1;
        win_rd    = lsu_rd;
        win_data  = lsu_data;
      end
      mdu_win: begin
        win_valid = 1'b1;
        win_rd    = mdu_rd;
        win_data  = mdu_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= GNT_MDU;
    end else if (lsu_win) begin
      last_grant <= GNT_LSU;
    end else if (mdu_win) begin
      last_grant <= GNT_MDU;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd         <= '0;
      data_des   <= '0;
      data_valid <= 1'b0;
    end else if (win_valid && win_rd != 5'd0) begin
      rd         <= win_rd;
      data_des   <= win_data;
      data_valid <= 1'b1;
    end else begin
      data_valid <= 1'b0;
    end
  end

  // Set is applied after clear so a same-edge realloc keeps the bit
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (alloc_valid && alloc_rd != 5'd0) begin
      set_mask[alloc_rd] = 1'b1;
    end
    if (data_valid) begin
      clr_mask[rd] = 1'b1;
    end
    busy_next    = (busy & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

`ifdef REGFILE_WB_FORWARD_EN
  assign fwd_hit  = data_valid && (rd == fwd_rs) && (fwd_rs != 5'd0);
  assign fwd_data = data_des;
`endif

endmodule
